// File: rtl/led_sweep_decoder.sv
// On-chip monitor for a bouncing one-hot LED bus: tracks position/direction,
// counts sweeps and violations. Optional stall check: LED_SWEEP_DECODER_STALL_CHECK_EN.
module led_sweep_decoder #(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH),
  parameter int CNT_W = 16
`ifdef LED_SWEEP_DECODER_STALL_CHECK_EN
  ,
  parameter int HOLD_MAX = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_in,
  input  logic             sample_en,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] sweep_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [POS_W-1:0] POS_BOT    = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_BOT_P1 = POS_W'(1);
  localparam logic [POS_W-1:0] POS_TOP    = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] POS_TOP_M1 = POS_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [POS_W:0]   EXT_ONE    = (POS_W + 1)'(1);

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return $onehot(v);
  endfunction

  // Index is only meaningful when the input is one-hot.
  function automatic logic [POS_W-1:0] onehot_idx(input logic [WIDTH-1:0] v);
    logic [POS_W-1:0] idx;
    idx = {POS_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = POS_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             locked_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  logic             sample_oh_s;
  logic [POS_W-1:0] sample_idx_s;
  logic [POS_W:0]   pos_ext_s;
  logic [POS_W:0]   idx_ext_s;
  logic             step_up_s;
  logic             step_dn_s;
  logic             same_s;
  logic             turn_s;
  logic             reload_s;
  logic             fwd_s;
  logic             stall_hit_s;
  logic             viol_s;

  assign sample_oh_s  = is_onehot(led_in);
  assign sample_idx_s = onehot_idx(led_in);

  // Extra MSB keeps pos+1 / pos-1 from wrapping across the bus ends.
  assign pos_ext_s = {1'b0, pos_q};
  assign idx_ext_s = {1'b0, sample_idx_s};
  assign step_up_s = (idx_ext_s == pos_ext_s + EXT_ONE);
  assign step_dn_s = (pos_ext_s == idx_ext_s + EXT_ONE);
  assign same_s    = (sample_idx_s == pos_q);

  assign turn_s   = ((pos_q == POS_TOP) && dir_q && (sample_idx_s == POS_TOP_M1)) ||
                    ((pos_q == POS_BOT) && !dir_q && (sample_idx_s == POS_BOT_P1));
  assign reload_s = ((pos_q == POS_BOT) && (sample_idx_s == POS_TOP)) ||
                    ((pos_q == POS_TOP) && (sample_idx_s == POS_BOT));
  assign fwd_s    = dir_q ? step_up_s : step_dn_s;

`ifdef LED_SWEEP_DECODER_STALL_CHECK_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  assign stall_hit_s = (hold_q == HOLD_W'(HOLD_MAX - 1));

  // Count consecutive unchanged samples while locked; any other sample clears it.
  always_comb begin
    hold_d = hold_q;
    if (!sample_en) begin
      hold_d = hold_q;
    end else if ((state_q == ST_LOCKED) && sample_oh_s && same_s && !stall_hit_s) begin
      hold_d = hold_q + HOLD_W'(1);
    end else begin
      hold_d = {HOLD_W{1'b0}};
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= {HOLD_W{1'b0}};
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign stall_hit_s = 1'b0;
`endif

  // Tracking FSM and counter next-state.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    sweep_d = sweep_q;
    viol_s  = 1'b0;
    if (sample_en) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (sample_oh_s) begin
            state_d = ST_ACQUIRE;
            pos_d   = sample_idx_s;
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_ACQUIRE: begin
          if (!sample_oh_s) begin
            state_d = ST_UNLOCKED;
          end else if (same_s) begin
            state_d = ST_ACQUIRE;
          end else if (step_up_s || step_dn_s) begin
            state_d = ST_LOCKED;
            dir_d   = step_up_s;
            pos_d   = sample_idx_s;
          end else begin
            pos_d = sample_idx_s;
          end
        end
        ST_LOCKED: begin
          if (!sample_oh_s) begin
            viol_s  = 1'b1;
            state_d = ST_UNLOCKED;
          end else if (same_s) begin
            if (stall_hit_s) begin
              viol_s  = 1'b1;
              state_d = ST_ACQUIRE;
            end else begin
              state_d = ST_LOCKED;
            end
          end else if (turn_s || reload_s) begin
            dir_d   = ~dir_q;
            pos_d   = sample_idx_s;
            sweep_d = sat_inc(sweep_q);
          end else if (fwd_s) begin
            pos_d = sample_idx_s;
          end else begin
            viol_s  = 1'b1;
            state_d = ST_ACQUIRE;
            pos_d   = sample_idx_s;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Violation pulse and saturating error count.
  always_comb begin
    err_d  = 1'b0;
    errc_d = errc_q;
    if (viol_s) begin
      err_d  = 1'b1;
      errc_d = sat_inc(errc_q);
    end else begin
      err_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_UNLOCKED;
      pos_q    <= {POS_W{1'b0}};
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      sweep_q  <= {CNT_W{1'b0}};
      errc_q   <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      locked_q <= (state_d == ST_LOCKED);
      err_q    <= err_d;
      sweep_q  <= sweep_d;
      errc_q   <= errc_d;
    end
  end

  assign pos       = pos_q;
  assign dir       = dir_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_q;
  assign err_cnt   = errc_q;

endmodule

// File: tb/tb_led_sweep_decoder.sv
// Randomized and directed bench for led_sweep_decoder against a behavioural model.
module tb_led_sweep_decoder;

  localparam int W  = 8;
  localparam int PW = 3;
  localparam int CW = 16;
  localparam int HM = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  led_in;
  logic          sample_en;
  logic [PW-1:0] pos;
  logic          dir;
  logic          locked;
  logic          err;
  logic [CW-1:0] sweep_cnt;
  logic [CW-1:0] err_cnt;

  int total;
  int bad;

  // Reference model state: 0 = unlocked, 1 = acquiring, 2 = locked.
  int m_state;
  int m_pos;
  bit m_dir;
  bit m_err;
  int m_sweep;
  int m_errc;
  int m_hold;

  led_sweep_decoder dut (
    .clk       (clk),
    .rst       (rst_n),
    .led_in    (led_in),
    .sample_en (sample_en),
    .pos       (pos),
    .dir       (dir),
    .locked    (locked),
    .err       (err),
    .sweep_cnt (sweep_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < W; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_dir = 0; m_err = 0;
    m_sweep = 0; m_errc = 0; m_hold = 0;
  endtask

  task automatic model_step(input logic [W-1:0] v, input bit en);
    bit oh;
    bit viol;
    bit held;
    int np;
    m_err = 0;
    if (!en) return;
    oh   = ($countones(v) == 1);
    np   = idx_of(v);
    viol = 0;
    held = 0;
    if (m_state == 0) begin
      if (oh) begin m_state = 1; m_pos = np; end
    end else if (m_state == 1) begin
      if (!oh) m_state = 0;
      else if (np == m_pos) m_state = 1;
      else if (np == m_pos + 1 || np == m_pos - 1) begin
        m_state = 2; m_dir = (np > m_pos); m_pos = np;
      end else m_pos = np;
    end else begin
      if (!oh) begin
        viol = 1; m_state = 0;
      end else if (np == m_pos) begin
        held = 1;
        m_hold++;
`ifdef LED_SWEEP_DECODER_STALL_CHECK_EN
        if (m_hold >= HM) begin viol = 1; m_state = 1; held = 0; end
`endif
      end else if ((m_pos == W-1 && m_dir && np == W-2) || (m_pos == 0 && !m_dir && np == 1) ||
                   (m_pos == 0 && np == W-1) || (m_pos == W-1 && np == 0)) begin
        m_dir = !m_dir; m_pos = np;
        if (m_sweep < (1 << CW) - 1) m_sweep++;
      end else if (m_dir ? (np == m_pos + 1) : (np == m_pos - 1)) begin
        m_pos = np;
      end else begin
        viol = 1; m_state = 1; m_pos = np;
      end
    end
    if (!held) m_hold = 0;
    if (viol) begin
      m_err = 1;
      if (m_errc < (1 << CW) - 1) m_errc++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pos"}, 32'(pos), 32'(m_pos));
    chk({tag, "_dir"}, 32'(dir), 32'(m_dir));
    chk({tag, "_locked"}, 32'(locked), 32'(m_state == 2));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_sweep"}, 32'(sweep_cnt), 32'(m_sweep));
    chk({tag, "_errc"}, 32'(err_cnt), 32'(m_errc));
  endtask

  task automatic step(input logic [W-1:0] v, input bit en, input string tag);
    led_in    = v;
    sample_en = en;
    @(posedge clk);
    model_step(v, en);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pos0"}, 32'(pos), 32'd0);
    chk({tag, "_dir0"}, 32'(dir), 32'd0);
    chk({tag, "_locked0"}, 32'(locked), 32'd0);
    chk({tag, "_err0"}, 32'(err), 32'd0);
    chk({tag, "_sweep0"}, 32'(sweep_cnt), 32'd0);
    chk({tag, "_errc0"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_en = 1'b0;
    model_reset();
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] v;
    int gpos;
    bit gdir;
    bit en;
    int r;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    led_in = '0;
    sample_en = 1'b0;
    model_reset();
    #2;
    check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Lock-on from top going down.
    step(8'h80, 1'b1, "t1a");
    chk("t1a_unlocked", 32'(locked), 32'd0);
    step(8'h40, 1'b1, "t1b");
    chk("t1b_locked", 32'(locked), 32'd1);
    chk("t1b_dir", 32'(dir), 32'd0);
    chk("t1b_pos", 32'(pos), 32'd6);
    step(8'h20, 1'b1, "t1c");
    chk("t1c_pos", 32'(pos), 32'd5);

    // Bottom turnaround, then top turnaround.
    for (int i = 4; i >= 0; i--) step(W'(1) << i, 1'b1, "t2dn");
    step(8'h02, 1'b1, "t2a");
    chk("t2a_dir", 32'(dir), 32'd1);
    chk("t2a_pos", 32'(pos), 32'd1);
    chk("t2a_sweep", 32'(sweep_cnt), 32'd1);
    for (int i = 2; i <= 7; i++) step(W'(1) << i, 1'b1, "t2up");
    step(8'h40, 1'b1, "t2b");
    chk("t2b_sweep", 32'(sweep_cnt), 32'd2);
    chk("t2b_dir", 32'(dir), 32'd0);

    // Wrong-direction step.
    step(8'h20, 1'b1, "t3p");
    step(8'h10, 1'b1, "t3q");
    step(8'h20, 1'b1, "t3a");
    chk("t3a_err", 32'(err), 32'd1);
    chk("t3a_errc", 32'(err_cnt), 32'd1);
    chk("t3a_locked", 32'(locked), 32'd0);
    chk("t3a_pos", 32'(pos), 32'd5);
    step(8'h00, 1'b0, "t3idle");
    chk("t3idle_err", 32'(err), 32'd0);
    step(8'h40, 1'b1, "t3b");
    chk("t3b_locked", 32'(locked), 32'd1);
    chk("t3b_dir", 32'(dir), 32'd1);

    // Non-one-hot while locked, then in unlocked.
    do_reset();
    step(8'h01, 1'b1, "t4p");
    step(8'h02, 1'b1, "t4q");
    step(8'h00, 1'b1, "t4a");
    chk("t4a_err", 32'(err), 32'd1);
    chk("t4a_errc", 32'(err_cnt), 32'd1);
    chk("t4a_locked", 32'(locked), 32'd0);
    step(8'h18, 1'b1, "t4b");
    chk("t4b_err", 32'(err), 32'd0);
    chk("t4b_locked", 32'(locked), 32'd0);
    step(8'h08, 1'b1, "t4c");
    chk("t4c_pos", 32'(pos), 32'd3);

    // Idle bus noise, then asynchronous reset mid-sweep.
    step(8'h10, 1'b1, "t5p");
    step(8'h20, 1'b1, "t5q");
    for (int i = 0; i < 100; i++) step(W'($urandom_range(0, 255)), 1'b0, "t5idle");
    chk("t5_pos_kept", 32'(pos), 32'd5);
    chk("t5_locked_kept", 32'(locked), 32'd1);
    step(8'h40, 1'b1, "t5r");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("t5rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h04, 1'b1, "t5post");
    chk("t5post_pos", 32'(pos), 32'd2);

    // Repeated samples while locked.
    step(8'h08, 1'b1, "t6p");
    step(8'h10, 1'b1, "t6q");
    for (int i = 0; i < 3; i++) step(8'h10, 1'b1, "t6hold");
    chk("t6_pre_err", 32'(err), 32'd0);
    step(8'h10, 1'b1, "t6a");
`ifdef LED_SWEEP_DECODER_STALL_CHECK_EN
    chk("t6a_err", 32'(err), 32'd1);
    chk("t6a_locked", 32'(locked), 32'd0);
    chk("t6a_errc", 32'(err_cnt), 32'd1);
`else
    chk("t6a_err", 32'(err), 32'd0);
    chk("t6a_locked", 32'(locked), 32'd1);
    chk("t6a_errc", 32'(err_cnt), 32'd0);
`endif

    // Random shifter-like traffic with corruption, holds and reloads.
    gpos = 4;
    gdir = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 99);
      if (!en) begin
        v = W'($urandom_range(0, 255));
      end else if (r < 4) begin
        v = W'($urandom_range(0, 255));
      end else if (r < 8) begin
        v = W'(1) << $urandom_range(0, W-1);
      end else if (r < 16) begin
        v = W'(1) << gpos;
      end else if (r < 24 && (gpos == 0 || gpos == W-1)) begin
        gpos = (W-1) - gpos;
        gdir = (gpos == 0);
        v = W'(1) << gpos;
      end else begin
        if (gdir) begin
          if (gpos == W-1) begin gdir = 1'b0; gpos = W-2; end
          else gpos++;
        end else begin
          if (gpos == 0) begin gdir = 1'b1; gpos = 1; end
          else gpos--;
        end
        v = W'(1) << gpos;
      end
      step(v, en, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sweep_decoder.md
Name: led_sweep_decoder

Overview:
- Reader/checker for the bouncing one-hot LED bus driven by the LED shifter.
- Samples the LED bus on a tick strobe and decodes the lit position and travel direction.
- Locks onto a legal bounce sequence, counts completed sweeps and flags protocol violations.
- Sits beside the shifter as an on-chip monitor; outputs feed status LEDs or a UART reporter.

Parameters:
WIDTH, 8, number of LEDs on the bus (>=2)
POS_W, $clog2(WIDTH), width of position output
CNT_W, 16, width of sweep and error counters
HOLD_MAX, 4, max consecutive unchanged samples before stall error (feature only)

Ports:
clk  input  1  system clock (12 MHz)
rst  input  1  asynchronous active-low reset
led_in  input  WIDTH  LED bus under observation, synchronous to clk
sample_en  input  1  one-cycle tick strobe; led_in evaluated only when high
pos  output  POS_W  index of lit bit (bit 0 = LSB)
dir  output  1  1 = moving toward MSB (up), 0 = toward LSB (down)
locked  output  1  high while in LOCKED
err  output  1  one-cycle pulse on a violation while LOCKED
sweep_cnt  output  CNT_W  completed endpoint turnarounds, saturating
err_cnt  output  CNT_W  violations counted, saturating

Behaviour:
- Reset (rst low, async): state UNLOCKED; pos=0, dir=0, locked=0, err=0, sweep_cnt=0, err_cnt=0; internal hold counter 0.
- All outputs registered; a sample taken in cycle N is reflected on outputs in cycle N+1. err is high only in N+1.
- No state change when sample_en is low.
- One-hot test: exactly one bit set; all-zero and multi-bit count as illegal.
- Adjacent: new index = pos±1 (no wrap; WIDTH-1 and 0 are not adjacent).
- UNLOCKED: one-hot sample -> ACQUIRE, pos latched. Otherwise stay.
- ACQUIRE:
  - Adjacent one-hot -> LOCKED; dir = (new>pos); pos updated.
  - Same value -> stay.
  - Non-adjacent one-hot -> stay in ACQUIRE, pos re-latched.
  - Illegal -> UNLOCKED.
  - No err in ACQUIRE.
- LOCKED legal steps:
  - Interior with dir=1: pos+1. With dir=0: pos-1.
  - Unchanged value: hold; no error in base build.
  - At pos=WIDTH-1 with dir=1: next sample WIDTH-2 -> dir=0, sweep_cnt+1.
  - At pos=0 with dir=0: next sample 1 -> dir=1, sweep_cnt+1.
  - Endpoint jump straight to opposite end (e.g. 0 -> WIDTH-1): legal reload; dir inverted, sweep_cnt+1. Covers the shifter's endpoint reload.
- LOCKED violations (wrong-direction step, non-adjacent jump, non-one-hot):
  - err pulse; err_cnt+1.
  - Non-one-hot -> UNLOCKED, pos/dir held.
  - One-hot -> ACQUIRE with pos re-latched.
- Counters saturate at all-ones. sweep_cnt and err_cnt increment together never occurs.
- rst asserted mid-sequence clears everything immediately. A sample_en on the first cycle after release is evaluated normally.

Optional Feature:
LED_SWEEP_DECODER_STALL_CHECK_EN:
- Defined: in LOCKED, consecutive unchanged samples are counted. Reaching HOLD_MAX triggers an err pulse, err_cnt+1 and a move to ACQUIRE. Any change clears the count.
- Undefined: holds are ignored indefinitely and the hold counter is not built.

Test Plan:
1. Reset, then samples 0x80,0x40,0x20 -> after 2nd sample locked=1, dir=0, pos=6; after 3rd pos=5, err never high.
2. Locked down sweep to 0x01, then 0x02 -> dir=1, pos=1, sweep_cnt=1; continue to 0x80 then 0x40 -> sweep_cnt=2, dir=0.
3. Locked at pos=4 dir=0, sample 0x20 (wrong direction) -> err pulse 1 cycle, err_cnt=1, locked=0, state ACQUIRE with pos=5; then 0x40 -> relock dir=1.
4. Locked, sample 0x00 then 0x18 -> first gives err, err_cnt=1, locked=0; second gives no err and stays unlocked; sample 0x08 -> ACQUIRE pos=3.
5. sample_en low for 100 cycles with random led_in -> outputs unchanged. Assert rst mid-sweep -> all outputs 0 asynchronously.
6. With STALL_CHECK_EN defined and HOLD_MAX=4: locked, then 0x10 repeated 4 more samples -> err on 4th repeat, err_cnt+1, locked=0. Without the macro -> no err.
